// File: rtl/pwm_audio_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pwm_audio_out                                                    |
// | Brief   : Volume scaling, click-free mute ramp and 1-bit PWM audio output; |
// |           PWM_AUDIO_SIGMA_DELTA_EN selects a first-order sigma-delta stage.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pwm_audio_out #(
  parameter int unsigned RAMP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic [2:0] volume,
  input  logic       mute,
  output logic       pwm_out,
  output logic       period_start,
  output logic       muted
);

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_MUTED    = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_t;

  localparam logic [3:0] c_step_last = 4'(RAMP_DIV - 1);

  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         duty_q, duty_d;
  logic               pwm_out_q, pwm_out_d;
  logic               period_start_q, period_start_d;
  state_t             state_q, state_d;
  logic [4:0]         r_q, r_d;
  logic [3:0]         step_cnt_q, step_cnt_d;

  logic               at_b;
  logic               step_due;
  logic signed [8:0]  s;
  logic [3:0]         vol_gain;
  logic signed [12:0] prod_v;
  logic signed [8:0]  v;
  logic signed [13:0] prod_e;
  logic [7:0]         duty_calc;

`ifdef PWM_AUDIO_SIGMA_DELTA_EN
  logic [8:0]         acc_q, acc_d;
`endif

  always_comb begin
    at_b      = (cnt_q == 8'hFF);
    s         = $signed({1'b0, sample}) - 9'sd128;
    vol_gain  = {1'b0, volume} + 4'd1;
    prod_v    = 13'(s) * 13'($signed({1'b0, vol_gain}));
    // Slicing off the low bits of a signed product is an arithmetic shift (floor).
    v         = $signed(prod_v[11:3]);
    prod_e    = 14'(v) * 14'($signed({1'b0, r_q}));
    duty_calc = prod_e[11:4] ^ 8'h80;
  end

  always_comb begin
    cnt_d          = cnt_q + 8'd1;
    period_start_d = at_b;
    duty_d         = duty_q;
    state_d        = state_q;
    r_d            = r_q;
    step_cnt_d     = step_cnt_q;
    step_due       = (step_cnt_q == c_step_last);

    if (at_b) begin
      // Uses r_q from before this boundary's ramp update.
      duty_d = (state_q == ST_MUTED) ? 8'd128 : duty_calc;

      if ((state_q == ST_FADE_OUT) || (state_q == ST_FADE_IN)) begin
        step_cnt_d = step_due ? 4'd0 : step_cnt_q + 4'd1;
      end else begin
        step_cnt_d = 4'd0;
      end

      case (state_q)
        ST_PLAY: begin
          if (mute) state_d = ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          if (!mute) begin
            state_d = ST_FADE_IN;
          end else if (step_due) begin
            if (r_q <= 5'd1) begin
              r_d     = 5'd0;
              state_d = ST_MUTED;
            end else begin
              r_d = r_q - 5'd1;
            end
          end
        end
        ST_MUTED: begin
          if (!mute) state_d = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (mute) begin
            state_d = ST_FADE_OUT;
          end else if (step_due) begin
            if (r_q >= 5'd15) begin
              r_d     = 5'd16;
              state_d = ST_PLAY;
            end else begin
              r_d = r_q + 5'd1;
            end
          end
        end
        default: begin
          state_d = ST_MUTED;
          r_d     = 5'd0;
        end
      endcase
    end
  end

`ifdef PWM_AUDIO_SIGMA_DELTA_EN
  always_comb begin
    acc_d     = {1'b0, acc_q[7:0]} + {1'b0, duty_q};
    pwm_out_d = acc_d[8];
  end
`else
  always_comb begin
    pwm_out_d = (cnt_q < duty_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= 8'd0;
      duty_q         <= 8'd128;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      state_q        <= ST_MUTED;
      r_q            <= 5'd0;
      step_cnt_q     <= 4'd0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      state_q        <= state_d;
      r_q            <= r_d;
      step_cnt_q     <= step_cnt_d;
    end
  end

`ifdef PWM_AUDIO_SIGMA_DELTA_EN
  always_ff @(posedge clk) begin
    if (rst) acc_q <= 9'd0;
    else     acc_q <= acc_d;
  end

  logic unused_bits;
  assign unused_bits = ^{prod_v[12], prod_v[2:0], prod_e[13:12], prod_e[3:0], acc_q[8]};
`else
  logic unused_bits;
  assign unused_bits = ^{prod_v[12], prod_v[2:0], prod_e[13:12], prod_e[3:0]};
`endif

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign muted        = (state_q == ST_MUTED);

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pwm_audio_out                                                 |
// | Brief   : Directed self-checking bench for pwm_audio_out (RAMP_DIV=1).     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample;
  logic [2:0] volume;
  logic       mute;
  logic       pwm_out;
  logic       period_start;
  logic       muted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_audio_out #(.RAMP_DIV(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .volume       (volume),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .muted        (muted)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Starts at a falling edge where cnt==0; ends at the next such edge.
  // Each sample reflects the comparison made for cnt = 0..255 of this period.
  task automatic run_period(input int chg_at, input logic [7:0] chg_sample,
                            input int pls_on, input int pls_off, output int ones);
    ones = 0;
    for (int j = 0; j < 256; j++) begin
      if (j == chg_at)  sample = chg_sample;
      if (j == pls_on)  mute   = 1'b1;
      if (j == pls_off) mute   = 1'b0;
      @(negedge clk);
      ones += int'(pwm_out);
    end
  endtask

  task automatic period_ones(input string tag, input int exp);
    int o;
    run_period(-1, 8'd0, -1, -1, o);
    check_eq(tag, o, exp);
  endtask

  function automatic int clamp16(input int x);
    if (x < 0)  return 0;
    if (x > 16) return 16;
    return x;
  endfunction

  // Fade-in from MUTED with sample=192, volume=7: duty = 128 + 4*r.
  task automatic fade_in_from_reset(input string pfx);
    for (int k = 0; k <= 18; k++) begin
      period_ones($sformatf("%s_k%0d", pfx, k), 128 + 4 * clamp16(k - 2));
      if (k == 0) check_eq({pfx, "_muted_after_b1"}, muted, 0);
    end
    check_eq({pfx, "_period_start"}, period_start, 1);
  endtask

  typedef struct {
    logic [7:0] smp;
    logic [2:0] vol;
    int         duty;
  } vec_t;

  vec_t vecs[6] = '{
    '{8'd192, 3'd3, 160},
    '{8'd0,   3'd7, 0},
    '{8'd255, 3'd7, 255},
    '{8'd64,  3'd0, 120},
    '{8'd127, 3'd0, 127},
    '{8'd192, 3'd7, 192}
  };

  initial begin
    int o;
    int prev_duty;
    int exp_d;
    logic prev_bit;
    int bad;

    rst    = 1'b1;
    mute   = 1'b0;
    sample = 8'd192;
    volume = 3'd7;
    repeat (4) @(negedge clk);
    check_eq("rst_pwm_out", pwm_out, 0);
    check_eq("rst_period_start", period_start, 0);
    check_eq("rst_muted", muted, 1);
    rst = 1'b0;
    check_eq("muted_before_b1", muted, 1);

    fade_in_from_reset("fadein");

    // Steady-state volume/sample vectors: old duty for the current period, new after B.
    prev_duty = 192;
    foreach (vecs[i]) begin
      sample = vecs[i].smp;
      volume = vecs[i].vol;
      period_ones($sformatf("vec%0d_old", i), prev_duty);
      period_ones($sformatf("vec%0d_new", i), vecs[i].duty);
      prev_duty = vecs[i].duty;
    end

    // Sample change at cnt=100 must not affect the running period.
    run_period(100, 8'd64, -1, -1, o);
    check_eq("midchg_cur", o, 192);
    period_ones("midchg_next", 64);

    // Mute pulse entirely between two boundaries is ignored.
    run_period(-1, 8'd0, 10, 200, o);
    check_eq("pulse_cur", o, 64);
    period_ones("pulse_next", 64);
    check_eq("pulse_muted", muted, 0);

    sample = 8'd192;
    period_ones("resettle", 64);

    // Fade out, reverse at r=8, fade back in to PLAY.
    mute = 1'b1;
    period_ones("rev_pre", 192);
    for (int i = 0; i <= 18; i++) begin
      if (i == 8) mute = 1'b0;
      exp_d = (i <= 9) ? 128 + 4 * clamp16(17 - i) : 128 + 4 * clamp16(i - 2);
      period_ones($sformatf("rev_i%0d", i), exp_d);
      check_eq($sformatf("rev_muted_i%0d", i), muted, 0);
    end

    // Reset at cnt=50 of an active period.
    repeat (50) @(negedge clk);
    check_eq("pre_rst_pwm", pwm_out, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_pwm_out", pwm_out, 0);
    check_eq("midrst_muted", muted, 1);
    check_eq("midrst_period_start", period_start, 0);
    rst = 1'b0;
    fade_in_from_reset("refade");

    // Full fade-out to MUTED.
    mute = 1'b1;
    period_ones("fo_pre", 192);
    for (int i = 0; i <= 17; i++) begin
      exp_d = (i >= 17) ? 128 : 128 + 4 * clamp16(17 - i);
      period_ones($sformatf("fo_i%0d", i), exp_d);
      check_eq($sformatf("fo_muted_i%0d", i), muted, (i >= 15) ? 1 : 0);
    end

`ifdef PWM_AUDIO_SIGMA_DELTA_EN
    // duty=128 must produce a strict 1,0 alternation.
    prev_bit = pwm_out;
    bad      = 0;
    o        = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (pwm_out == prev_bit) bad++;
      prev_bit = pwm_out;
      o += int'(pwm_out);
    end
    check_eq("sd_repeats", bad, 0);
    check_eq("sd_ones", o, 128);
`else
    prev_bit = 1'b0;
    bad      = 0;
    period_ones("muted_duty", 128);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
